// File: rtl/module4_fine_cfo_apply_pkg.sv
// Shared widths and the S1 pipeline entry for the fine CFO multiplier scheduler.
// Imported by the scheduler top and its multiplier.
package module4_fine_cfo_apply_pkg;

    localparam int N_REQ   = 4;
    localparam int A_W     = 28;
    localparam int B_W     = 32;
    localparam int P_W     = 54;
    localparam int TAG_W   = 4;
    localparam int S1_ID_W = $clog2(N_REQ);

    typedef struct packed {
        logic signed [A_W-1:0]   a;
        logic signed [B_W-1:0]   b;
        logic [S1_ID_W-1:0]      id;
        logic [TAG_W-1:0]        tag;
    } s1_entry_t;

endpackage

// File: rtl/module4_fine_cfo_apply_mul_28s_32s_54_1_1.sv
// Combinational signed multiplier keeping the low P_W bits of A*B.
// Sits between the S1 and S2 registers of the scheduler.
module module4_fine_cfo_apply_mul_28s_32s_54_1_1 #(
    parameter int A_W = 28,
    parameter int B_W = 32,
    parameter int P_W = 54
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic signed [P_W-1:0] p_o
);

    // Sign-extend both operands to P_W first; the low bits of the
    // product are exact regardless of the discarded upper bits.
    assign p_o = P_W'(a_i) * P_W'(b_i);

endmodule

// File: rtl/module4_fine_cfo_apply_mul_sched.sv
// Round-robin scheduler sharing one signed multiplier among N_REQ requesters.
// Two-stage pipeline (operands, product) with full valid/ready backpressure.
module module4_fine_cfo_apply_mul_sched #(
    parameter int N_REQ = module4_fine_cfo_apply_pkg::N_REQ,
    parameter int A_W   = module4_fine_cfo_apply_pkg::A_W,
    parameter int B_W   = module4_fine_cfo_apply_pkg::B_W,
    parameter int P_W   = module4_fine_cfo_apply_pkg::P_W,
    parameter int TAG_W = module4_fine_cfo_apply_pkg::TAG_W
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_W-1:0]       req_a,
    input  logic [N_REQ*B_W-1:0]       req_b,
    input  logic [N_REQ*TAG_W-1:0]     req_tag,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [P_W-1:0]             res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic [TAG_W-1:0]           res_tag,
    output logic [15:0]                issue_cnt
);

    import module4_fine_cfo_apply_pkg::*;

    localparam int GW = $clog2(N_REQ);

    logic [GW-1:0]    last_q, last_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    s1_entry_t        s1_q, s1_d;
    logic [P_W-1:0]   s2_data_q, s2_data_d;
    logic [GW-1:0]    s2_id_q, s2_id_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [P_W-1:0]   prod;
    logic             gnt_any;
    logic [GW-1:0]    gnt_idx;
    logic [GW-1:0]    cand;
    logic             s1_load;
    logic             s2_load;
    logic             accept;

    module4_fine_cfo_apply_mul_28s_32s_54_1_1 #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .a_i (s1_q.a),
        .b_i (s1_q.b),
        .p_o (prod)
    );

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % N_REQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign s2_load = !s2_vld_q || res_ready;
    assign s1_load = !s1_vld_q || s2_load;

    // Only the winner sees ready, and only when S1 can take a new entry.
    always_comb begin
        req_ready = '0;
        if (!ap_rst && gnt_any && s1_load) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Next-state for arbiter pointer, counter and both pipeline stages.
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        s1_vld_d  = s1_vld_q;
        s1_d      = s1_q;
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_id_d   = s2_id_q;
        s2_tag_d  = s2_tag_q;
        if (accept) begin
            last_d   = gnt_idx;
            cnt_d    = cnt_q + 16'd1;
            s1_d.a   = req_a[int'(gnt_idx)*A_W +: A_W];
            s1_d.b   = req_b[int'(gnt_idx)*B_W +: B_W];
            s1_d.id  = gnt_idx;
            s1_d.tag = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
        end
        if (s1_load) begin
            s1_vld_d = accept;
        end
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_data_d = prod;
                s2_id_d   = s1_q.id;
                s2_tag_d  = s1_q.tag;
            end
        end
    end

    // State registers; reset empties the pipe and gives requester 0 priority.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last_q    <= GW'(N_REQ - 1);
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
            s2_tag_q  <= '0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_id_q   <= s2_id_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

    assign res_valid = s2_vld_q;
    assign res_data  = s2_data_q;
    assign res_id    = s2_id_q;
    assign res_tag   = s2_tag_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_module4_fine_cfo_apply_mul_sched.sv
// Self-checking bench for the round-robin multiplier scheduler.
// Directed scenarios plus random traffic against a FIFO/latency model.
module tb_module4_fine_cfo_apply_mul_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [111:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [15:0]  req_tag = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [53:0]  res_data;
    logic [1:0]   res_id;
    logic [3:0]   res_tag;
    logic [15:0]  issue_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [53:0] d;
        logic [1:0]  id;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    module4_fine_cfo_apply_mul_sched dut (
        .ap_clk    (clk),
        .ap_rst    (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_tag   (res_tag),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [53:0] exp_prod(
        input logic signed [27:0] a,
        input logic signed [31:0] b
    );
        longint p;
        p = longint'(a) * longint'(b);
        return p[53:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [27:0] a,
                           input logic [31:0] b, input logic [3:0] t);
        req_a[i*28 +: 28]  = a;
        req_b[i*32 +: 32]  = b;
        req_tag[i*4 +: 4]  = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== 4'h0) begin
                bad++;
                $display("FAIL rst_ready c=%0d got=%b exp=0000", c, req_ready);
            end
            tick();
        end
        total++;
        if (res_valid !== 1'b0 || issue_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_state got v=%b cnt=%0d exp v=0 cnt=0",
                     res_valid, issue_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rst_first_grant got=%b exp=0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        res_ready = 1'b1;
        set_req(0, 28'sd3, -32'sd5, 4'd7);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b exp=0", res_valid);
        end
        tick();
        total++;
        if (res_valid !== 1'b1 || res_data !== 54'h3FFFFFFFFFFFF1 ||
            res_id !== 2'd0 || res_tag !== 4'd7) begin
            bad++;
            $display("FAIL single_res got v=%b d=%h id=%0d t=%0d exp v=1 d=3ffffffffffff1 id=0 t=7",
                     res_valid, res_data, res_id, res_tag);
        end
        tick();
        total++;
        if (res_valid !== 1'b0 || issue_cnt !== 16'd1) begin
            bad++;
            $display("FAIL single_after got v=%b cnt=%0d exp v=0 cnt=1",
                     res_valid, issue_cnt);
        end
    endtask

    task automatic test_rr_stream();
        logic [27:0] a[4];
        logic [31:0] b[4];
        logic [3:0]  t[4];
        logic [53:0] ed[14];
        logic [3:0]  et[14];
        int g;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a[i] = 28'($urandom);
            b[i] = $urandom;
            t[i] = 4'($urandom);
            set_req(i, a[i], b[i], t[i]);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 14; c++) begin
            #1;
            g = c % 4;
            total++;
            if (req_ready !== 4'(1 << g)) begin
                bad++;
                $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, 4'(1 << g));
            end
            ed[c] = exp_prod(a[g], b[g]);
            et[c] = t[g];
            total++;
            if (c >= 2) begin
                if (res_valid !== 1'b1 || res_data !== ed[c-2] ||
                    res_id !== 2'((c - 2) % 4) || res_tag !== et[c-2]) begin
                    bad++;
                    $display("FAIL rr_res c=%0d got v=%b d=%h id=%0d exp v=1 d=%h id=%0d",
                             c, res_valid, res_data, res_id, ed[c-2], (c - 2) % 4);
                end
            end else if (res_valid !== 1'b0) begin
                bad++;
                $display("FAIL rr_fill c=%0d got v=%b exp v=0", c, res_valid);
            end
            tick();
            a[g] = 28'($urandom);
            b[g] = $urandom;
            t[g] = 4'($urandom);
            set_req(g, a[g], b[g], t[g]);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [53:0] d0, d1, d2;
        d0 = exp_prod(28'sd100, -32'sd7);
        d1 = exp_prod(-28'sd2000, 32'sd12345);
        d2 = exp_prod(28'sd55, 32'sd55);
        do_reset();
        set_req(0, 28'sd100, -32'sd7, 4'd1);
        set_req(1, -28'sd2000, 32'sd12345, 4'd2);
        set_req(2, 28'sd55, 32'sd55, 4'd3);
        req_valid = 4'b0111;
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (req_ready !== (c == 0 ? 4'b0001 : c == 1 ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL bp_ready c=%0d got=%b", c, req_ready);
            end
            if (c >= 2) begin
                total++;
                if (res_valid !== 1'b1 || res_data !== d0 ||
                    res_id !== 2'd0 || res_tag !== 4'd1) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d got v=%b d=%h id=%0d exp v=1 d=%h id=0",
                             c, res_valid, res_data, res_id, d0);
                end
            end
            tick();
            if (c == 0) req_valid = 4'b0110;
            if (c == 1) req_valid = 4'b0100;
        end
        total++;
        if (issue_cnt !== 16'd2) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=2", issue_cnt);
        end
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100 || res_valid !== 1'b1 || res_data !== d0) begin
            bad++;
            $display("FAIL bp_release got rdy=%b v=%b d=%h exp rdy=0100 v=1 d=%h",
                     req_ready, res_valid, res_data, d0);
        end
        tick();
        req_valid = '0;
        total++;
        if (res_valid !== 1'b1 || res_data !== d1 || res_id !== 2'd1 ||
            res_tag !== 4'd2) begin
            bad++;
            $display("FAIL bp_res1 got v=%b d=%h id=%0d exp v=1 d=%h id=1",
                     res_valid, res_data, res_id, d1);
        end
        tick();
        total++;
        if (res_valid !== 1'b1 || res_data !== d2 || res_id !== 2'd2 ||
            res_tag !== 4'd3) begin
            bad++;
            $display("FAIL bp_res2 got v=%b d=%h id=%0d exp v=1 d=%h id=2",
                     res_valid, res_data, res_id, d2);
        end
        tick();
        total++;
        if (res_valid !== 1'b0 || issue_cnt !== 16'd3) begin
            bad++;
            $display("FAIL bp_end got v=%b cnt=%0d exp v=0 cnt=3", res_valid, issue_cnt);
        end
    endtask

    task automatic test_extremes();
        logic [53:0] e1, e2;
        e1 = exp_prod(28'h8000000, 32'h80000000);
        e2 = exp_prod(28'h7FFFFFF, 32'h7FFFFFFF);
        do_reset();
        res_ready = 1'b1;
        set_req(1, 28'h8000000, 32'h80000000, 4'hA);
        req_valid = 4'b0010;
        tick();
        set_req(2, 28'h7FFFFFF, 32'h7FFFFFFF, 4'hB);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        total++;
        if ($isunknown(res_data) || res_data !== e1 || res_id !== 2'd1 ||
            res_valid !== 1'b1) begin
            bad++;
            $display("FAIL ext_min got v=%b d=%h id=%0d exp v=1 d=%h id=1",
                     res_valid, res_data, res_id, e1);
        end
        tick();
        total++;
        if ($isunknown(res_data) || res_data !== e2 || res_id !== 2'd2 ||
            res_valid !== 1'b1) begin
            bad++;
            $display("FAIL ext_max got v=%b d=%h id=%0d exp v=1 d=%h id=2",
                     res_valid, res_data, res_id, e2);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        res_ready = 1'b0;
        set_req(1, 28'sd11, 32'sd13, 4'd5);
        set_req(2, 28'sd17, 32'sd19, 4'd6);
        req_valid = 4'b0110;
        tick();
        tick();
        total++;
        if (res_valid !== 1'b1 || issue_cnt !== 16'd2) begin
            bad++;
            $display("FAIL mr_full got v=%b cnt=%0d exp v=1 cnt=2", res_valid, issue_cnt);
        end
        rst = 1'b1;
        set_req(0, 28'sd2, 32'sd21, 4'd9);
        req_valid = 4'hF;
        #1;
        total++;
        if (req_ready !== 4'h0) begin
            bad++;
            $display("FAIL mr_ready_in_rst got=%b exp=0000", req_ready);
        end
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        total++;
        if (res_valid !== 1'b0 || issue_cnt !== 16'd0 || req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mr_after got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=0001",
                     res_valid, issue_cnt, req_ready);
        end
        tick();
        req_valid = '0;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL mr_no_stale got v=%b exp v=0", res_valid);
        end
        tick();
        total++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 54'd42 ||
            res_tag !== 4'd9) begin
            bad++;
            $display("FAIL mr_next got v=%b id=%0d d=%h exp v=1 id=0 d=2a",
                     res_valid, res_id, res_data);
        end
        tick();
    endtask

    task automatic test_random(input int ncyc, input int dens);
        logic [3:0]  pend;
        logic [27:0] pa[4];
        logic [31:0] pb[4];
        logic [3:0]  pt[4];
        logic [3:0]  exp_rdy;
        logic        exp_rv;
        exp_t        q[$];
        exp_t        e;
        int          last, cyc, w, nacc;
        do_reset();
        pend = '0;
        last = 3;
        cyc = 0;
        nacc = 0;
        for (int n = 0; n < ncyc; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < dens) begin
                    pend[i] = 1'b1;
                    pa[i] = 28'($urandom);
                    pb[i] = $urandom;
                    pt[i] = 4'($urandom);
                    set_req(i, pa[i], pb[i], pt[i]);
                end
            end
            req_valid = pend;
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && pend[(last + k) % 4]) w = (last + k) % 4;
            end
            exp_rdy = '0;
            if (w >= 0 && (q.size() < 2 || res_ready)) exp_rdy[w] = 1'b1;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, exp_rdy);
            end
            exp_rv = q.size() > 0 && cyc >= q[0].acc + 1;
            total++;
            if (res_valid !== exp_rv) begin
                bad++;
                $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, res_valid, exp_rv);
            end
            if (exp_rv) begin
                total++;
                if (res_data !== q[0].d || res_id !== q[0].id ||
                    res_tag !== q[0].tag) begin
                    bad++;
                    $display("FAIL rnd_res n=%0d got d=%h id=%0d t=%0d exp d=%h id=%0d t=%0d",
                             n, res_data, res_id, res_tag, q[0].d, q[0].id, q[0].tag);
                end
                if (res_ready) void'(q.pop_front());
            end
            if (w >= 0 && exp_rdy != 4'h0) begin
                e.d = exp_prod(pa[w], pb[w]);
                e.id = 2'(w);
                e.tag = pt[w];
                e.acc = cyc + 1;
                q.push_back(e);
                pend[w] = 1'b0;
                last = w;
                nacc++;
            end
            tick();
            cyc++;
        end
        req_valid = '0;
        total++;
        if (issue_cnt !== 16'(nacc)) begin
            bad++;
            $display("FAIL rnd_count got=%0d exp=%0d", issue_cnt, nacc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        res_ready = 1'b1;
        set_req(0, 28'sd1, 32'sd1, 4'd0);
        req_valid = 4'b0001;
        repeat (65535) tick();
        total++;
        if (issue_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_ffff got=%h exp=ffff", issue_cnt);
        end
        tick();
        total++;
        if (issue_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero got=%h exp=0000", issue_cnt);
        end
        tick();
        req_valid = '0;
        total++;
        if (issue_cnt !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_one got=%h exp=0001", issue_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_stream();
        test_backpressure();
        test_extremes();
        test_mid_reset();
        test_random(600, 40);
        test_random(600, 90);
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
